// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the shared-bus arbiter: state encoding, default
// timeouts and index-width helpers.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_BUSY,
    ST_ABORT,
    ST_RELEASE
  } arb_state_e;

  localparam int DEF_NUM_MASTERS   = 4;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int DEF_BUSY_TIMEOUT  = 1024;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and transaction-tracking signals between the requesting
// masters (master side) and the arbiter (slave side).
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
);
  localparam int AW = idx_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] requestTransaction;
  logic [NUM_MASTERS-1:0] transactionGranted;
  logic                   beginTransactionIn;
  logic                   endTransactionIn;
  logic                   busErrorIn;
  logic                   endTransactionOut;
  logic                   busErrorOut;
  logic [AW-1:0]          activeMaster;
  logic                   busIdle;

  modport master (
    output requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
    input  transactionGranted, endTransactionOut, busErrorOut, activeMaster, busIdle
  );

  modport slave (
    input  requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
    output transactionGranted, endTransactionOut, busErrorOut, activeMaster, busIdle
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N.
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_MASTERS,
  localparam int AW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [AW-1:0] grant_idx,
  output logic          any_req
);

  int j;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any_req && req[j]) begin
        any_req     = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = AW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter: grants one master at a time, tracks the
// transaction and reclaims unused or hung grants.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int AW = idx_w(NUM_MASTERS);
  localparam int CW = idx_w((BUSY_TIMEOUT > GRANT_TIMEOUT) ? BUSY_TIMEOUT : GRANT_TIMEOUT);

  arb_state_e             state, state_n;
  logic [CW-1:0]          cnt;
  logic [AW-1:0]          ptr;
  logic [AW-1:0]          active;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] sel_oh;
  logic [AW-1:0]          sel_idx;
  logic                   sel_any;

  // Bus errors are the holding master's business; the arbiter never acts on them.
  logic unused_bus_err;
  assign unused_bus_err = bus.busErrorIn;

  rr_priority_select #(.N(NUM_MASTERS)) u_sel (
    .req       (bus.requestTransaction),
    .ptr       (ptr),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx),
    .any_req   (sel_any)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (sel_any) state_n = ST_GRANTED;
      ST_GRANTED: begin
        if (bus.beginTransactionIn)                   state_n = ST_BUSY;
        else if (!bus.requestTransaction[active])     state_n = ST_RELEASE;
        else if (cnt == CW'(GRANT_TIMEOUT - 1))       state_n = ST_RELEASE;
      end
      ST_BUSY: begin
        if (bus.endTransactionIn)                     state_n = ST_RELEASE;
        else if (cnt == CW'(BUSY_TIMEOUT - 1))        state_n = ST_ABORT;
      end
      ST_ABORT:   state_n = ST_RELEASE;
      ST_RELEASE: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ptr    <= '0;
      active <= '0;
      grant  <= '0;
    end else begin
      state <= state_n;
      // One counter serves both the grant and busy watchdogs; it restarts on every state change.
      if (state_n != state) cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CW'(1);
      if (state == ST_IDLE && sel_any) begin
        grant  <= sel_oh;
        active <= sel_idx;
      end
      if (state == ST_RELEASE) begin
        grant <= '0;
        ptr   <= (active == AW'(NUM_MASTERS - 1)) ? '0 : active + AW'(1);
      end
    end
  end

  assign bus.transactionGranted = grant;
  assign bus.activeMaster       = active;
  assign bus.endTransactionOut  = (state == ST_ABORT);
  assign bus.busErrorOut        = (state == ST_ABORT);
  assign bus.busIdle            = (state == ST_IDLE);

endmodule
